mix_state_digest: RTL
=====================

// Module: mix_state_digest
// PURPOSE
//  Downstream consumer of the 8x32b mixing-state register bank. Each accepted sample
//  (all 8 words) is folded to 32b and chained into a running signature. Every
//  FRAME_LEN samples it emits one digest word, buffered in a small FIFO, with a
//  valid/ready handshake. Used to compress mixer output for cross-checking simulators.
// PARAMETERS
//  FRAME_LEN   16          samples per digest, >=1
//  NUM_FRAMES  4           digests per run (start..done), >=1
//  FIFO_DEPTH  4           digest FIFO entries, power of 2, >=2
//  SEED        32'h0       accumulator value at start of each frame
// PORTS
//  clk        in   1    clock; all logic on posedge
//  rst        in   1    synchronous reset, active-high
//  start      in   1    1-cycle pulse: begin a run (ignored unless IDLE)
//  s_valid    in   1    state sample valid
//  s_ready    out  1    sample accepted when s_valid&&s_ready
//  s_data     in   256  {o7,o6,...,o0}; o0 = bits[31:0]
//  d_valid    out  1    digest available (FIFO not empty)
//  d_ready    in   1    digest consumed when d_valid&&d_ready
//  d_data     out  32   digest at FIFO head
//  d_frame    out  8    frame index of head digest (mod 256)
//  busy       out  1    high in RUN or DRAIN
//  done       out  1    1-cycle pulse on DRAIN->IDLE
// BEHAVIOUR
//  Reset: state IDLE, acc=SEED, cnt=0, frame=0, FIFO empty; s_ready=0, d_valid=0,
//   d_data=0, d_frame=0, busy=0, done=0. Reset mid-run discards FIFO contents.
//  Fold (comb): f = XOR over i=0..7 of rotl(o_i, 4*i); all arithmetic mod 2^32.
//  Chain: on accept, acc_nxt = rotl(acc,5) + f.
//  FSM:
//   IDLE : s_ready=0. start -> RUN, acc=SEED, cnt=0, frame=0.
//   RUN  : s_ready = !fifo_full. On accept: if cnt==FRAME_LEN-1 push {frame,acc_nxt},
//          acc=SEED, cnt=0, frame++; if frame==NUM_FRAMES-1 -> DRAIN. Else acc=acc_nxt, cnt++.
//   DRAIN: s_ready=0; when FIFO empty (incl. same cycle last pop) -> IDLE, done=1 for 1 cycle.
//  start while busy: ignored, no effect on state.
//  Latency: digest visible on d_valid the cycle after the accepting edge of the
//   last sample in a frame (registered FIFO, no comb bypass).
//  FIFO: push and pop in same cycle allowed (occupancy unchanged); push never
//   happens when full because s_ready gates it; d_data/d_frame stable while d_valid&&!d_ready.
//  s_data sampled only on accept; s_valid without s_ready has no effect.
//  FRAME_LEN=1: every accepted sample pushes a digest.
// STRUCTURE
//  Package mix_digest_pkg: state enum {IDLE,RUN,DRAIN}, ROT_STEP=4, CHAIN_ROT=5,
//   function fold8(256b)->32b shared with the bench reference model.
//  Sub-module digest_fifo #(WIDTH=40, DEPTH): sync FIFO, full/empty, ptr wrap.
//  Top: FSM, counters, accumulator, fold logic.
// TESTING
//  1 FRAME_LEN=1,SEED=0, start, sample o0=1 others 0 -> d_data=32'h1, d_frame=0 next cycle.
//  2 FRAME_LEN=2,SEED=0, two samples o0=1 -> one digest 32'h21 (rotl(1,5)+1=33).
//  3 FRAME_LEN=1, sample o1=1 others 0 -> 32'h10; o7=32'h1 only -> 32'h1000_0000.
//  4 FIFO_DEPTH=2, NUM_FRAMES=4, d_ready=0: s_ready drops after 2 digests; raise
//    d_ready -> remaining frames flow, d_frame 0,1,2,3 in order, then done pulse.
//  5 rst asserted mid-RUN with 1 digest queued -> next cycle all outputs at reset values.
//  6 start pulsed during RUN and DRAIN -> no effect; random samples vs fold8 model match.

Source files
------------

// File: rtl/mix_state_digest_pkg.sv
// Shared types and helpers for the mixing-state digest block.
// fold8 is the single definition of the 256b->32b fold used by design and reference model.
package mix_digest_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam int ROT_STEP  = 4;
   localparam int CHAIN_ROT = 5;

   // Rotate left via a doubled word so a zero rotate needs no special case
   function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
      logic [63:0] d;
      d = {x, x} << (n % 32);
      return d[63:32];
   endfunction

   function automatic logic [31:0] fold8(input logic [255:0] s);
      logic [31:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         f = f ^ rotl32(s[32*i +: 32], ROT_STEP * i);
      end
      return f;
   endfunction

endpackage

// File: rtl/mix_state_digest_fifo.sv
// Synchronous FIFO holding {frame, digest} entries; pointers carry an extra wrap bit.
// The head is forced to zero while empty so the digest outputs idle at zero.
module digest_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/mix_state_digest.sv
// Folds each accepted 8x32b mixer sample, chains it into a running signature and
// queues one digest per frame of FRAME_LEN samples for a downstream consumer.
module mix_state_digest
   import mix_digest_pkg::*;
#(
   parameter int          FRAME_LEN  = 16,
   parameter int          NUM_FRAMES = 4,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] SEED       = 32'h0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [255:0] s_data,
   output logic         d_valid,
   input  logic         d_ready,
   output logic [31:0]  d_data,
   output logic [7:0]   d_frame,
   output logic         busy,
   output logic         done
);

   localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] acc;
   logic [31:0] acc_nxt;
   logic [CW-1:0] cnt;
   logic [31:0] frame;
   logic        accept;
   logic        last_sample;
   logic        push;
   logic        pop;
   logic        drain_exit;
   logic        fifo_full;
   logic        fifo_empty;
   logic [AW:0] fifo_count;
   logic [39:0] fifo_head;

   assign acc_nxt     = rotl32(acc, CHAIN_ROT) + fold8(s_data);
   assign accept      = s_valid && s_ready;
   assign last_sample = (cnt == CW'(FRAME_LEN - 1));
   assign push        = accept && last_sample;
   assign pop         = d_ready && !fifo_empty;
   // A pop that empties the FIFO lets DRAIN finish in the same cycle
   assign drain_exit  = (state == DRAIN) &&
                        (fifo_empty || (fifo_count == (AW+1)'(1) && pop));

   assign d_valid = !fifo_empty;
   assign d_data  = fifo_head[31:0];
   assign d_frame = fifo_head[39:32];
   assign busy    = (state != IDLE);

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            s_ready = !fifo_full;
            if (push && frame == 32'(NUM_FRAMES - 1)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (drain_exit) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= SEED;
         cnt   <= '0;
         frame <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= drain_exit;
         if (state == IDLE && start) begin
            acc   <= SEED;
            cnt   <= '0;
            frame <= '0;
         end else if (accept) begin
            if (last_sample) begin
               acc   <= SEED;
               cnt   <= '0;
               frame <= frame + 1;
            end else begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   digest_fifo #(
      .WIDTH (40),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data ({frame[7:0], acc_nxt}),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

endmodule
